apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB4 completer that sits directly downstream of the APB master VIP on `apb_if` and replaces the dummy slave. It decodes word-aligned accesses into a bank of 32-bit registers, inserts a fixed number of wait states, honours byte strobes and flags illegal accesses with `pslverr`. Register 0 is a read-only ID register; all others are read/write scratch/config registers.

## Interface

- `ADDR_WIDTH`, 8: width of `paddr`.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`; only 32 is supported.
- `NUM_REGS`, 16: number of registers, index 0..NUM_REGS-1. Must be ≤ 2^(ADDR_WIDTH-2).
- `WAIT_CYCLES`, 1: wait states per access, 0..15.
- `ID_VALUE`, 32'hA5B0_0001: constant returned by register 0.

Ports:

- `pclk`  in  1  APB clock; all logic on its rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  write byte strobes.
- `pprot`  in  3  accepted and ignored.
- `prdata`  out  DATA_WIDTH  read data. Valid only in the cycle where `pready`=1; 0 otherwise.
- `pready`  out  1  transfer-complete indicator.
- `pslverr`  out  1  error indicator. Valid only with `pready`=1; 0 otherwise.

## Operation

- FSM states:
  - IDLE
  - ACCESS: a transfer is in flight.
- IDLE → ACCESS when `psel`=1 and `penable`=0 (setup phase).
  - At that edge the block latches `pwrite`, `paddr`, `pwdata` and `pstrb`.
  - It loads the wait counter with WAIT_CYCLES.
  - It sets `pready` to 1 if WAIT_CYCLES=0, else 0.
- ACCESS with `psel`=1 and `penable`=1:
  - While counter ≠ 0: decrement it. When it reaches 0, `pready` is 1 in the next cycle.
  - In the cycle with `pready`=1 the transfer completes. The register effect is applied at the end of that cycle, and the FSM returns to IDLE.
  - `pready` is high for exactly one cycle.
- ACCESS with `psel`=0: abort the transfer.
  - Return to IDLE with no register update.
  - `pready` and `pslverr` are 0.
- Error decode, evaluated on the latched address. If any condition holds, `pslverr`=1 in the completion cycle:
  - Misaligned: `paddr[1:0]` ≠ 0.
  - Out of range: index `paddr[ADDR_WIDTH-1:2]` ≥ NUM_REGS.
  - Write to register 0.
- Error transfers never modify state. Error reads return `prdata`=0.
- Writes: for each byte lane b with `pstrb[b]`=1, write `reg[idx][8b+7:8b]` from `pwdata`. Lanes with a 0 strobe are unchanged. `pstrb`=0 is a legal no-op write with `pslverr`=0.
- Reads: `prdata` = `reg[idx]` as it stands in the completion cycle. Register 0 reads return ID_VALUE.
- `pprot` has no effect.

## Timing

- Reset (`preset`=1 at a rising edge):
  - FSM goes to IDLE and the counter to 0.
  - `pready`=0, `pslverr`=0, `prdata`=0.
  - Registers 1..NUM_REGS-1 are set to 0.
  - Reset overrides an in-flight transfer; no write occurs.
- Latency from setup cycle to completion cycle: WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0: completes in the first access cycle.
  - WAIT_CYCLES=1: completes in the second access cycle.
- Back-to-back transfers:
  - The cycle after completion may be a new setup phase (`psel`=1, `penable`=0). It is accepted with no idle gap.
  - A write followed by a read of the same register returns the new value.
- `penable`=1 while in IDLE is a protocol error by the master. It is ignored and the FSM stays in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Package `apb_slave_pkg` holds:
  - the state enum `apb_slv_state_e` (IDLE, ACCESS);
  - the default ID constant `APB_SLV_ID`;
  - a function `apb_slv_decode_err(addr, write)` that returns the error bit.
- One sub-module, `apb_slave_reg_bank`:
  - NUM_REGS×32 storage with per-byte write enables and a synchronous clear;
  - a combinational read mux with register 0 hardwired to ID_VALUE.
- The top-level holds the FSM, the wait counter, the address/data latches and the output registers.

## Test plan

- Reset then read `paddr`=0x00 (WAIT_CYCLES=1) → `pready` high in the 2nd access cycle, `prdata`=32'hA5B0_0001, `pslverr`=0.
- Write 0xDEADBEEF to 0x04 with `pstrb`=4'hF, then write 0x11223344 to 0x04 with `pstrb`=4'b0101, then read 0x04 → 32'hDE22BE44, no errors, back-to-back with no idle cycle.
- Each of the following → `pslverr`=1 in the completion cycle, `prdata`=0, and registers unchanged on a read-back of 0x08:
  - write to 0x00;
  - read 0x06 (misaligned);
  - read 0x40 with NUM_REGS=16 (out of range).
- Write 0x5 to 0x08, dropping `psel` after the first access cycle → no `pready`; a later read of 0x08 returns 0.
- Assert `preset` mid-ACCESS of a write of 0xFFFFFFFF to 0x0C → outputs 0 next cycle; a read of 0x0C after reset returns 0.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: read 0x00 → `pready` in access cycle 1 and access cycle 4 respectively, each high for exactly one cycle.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types, constants and address decode for the APB register-file completer.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam logic [31:0] APB_SLV_ID = 32'hA5B0_0001;

    // Error when misaligned, beyond the register bank, or a write to the ID register.
    function automatic logic apb_slv_decode_err(input logic [31:0] addr,
                                                input logic        write,
                                                input int unsigned num_regs = 16);
        logic [29:0] idx;
        idx = addr[31:2];
        return (addr[1:0] != 2'b00) || (32'(idx) >= num_regs) || (write && (idx == '0));
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between the master VIP and the register-file completer.
interface apb_slave_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_reg_bank.sv
// Register storage with per-byte writes and synchronous clear; register 0 reads as a constant ID.
module apb_slave_reg_bank #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 6,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data_c
);
    logic [31:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (wstrb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_data_c = '0;
        if (rd_idx == '0) rd_data_c = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data_c = regs[i];
        end
    end
endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: fixed wait states, byte strobes and pslverr decode over a small register bank.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = APB_SLV_ID
) (
    input  logic                pclk,
    input  logic                preset,
    apb_slave_regfile_if.slave  apb
);
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    apb_slv_state_e          state;
    logic [3:0]              cnt;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_W-1:0]       lat_strb;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic [ADDR_WIDTH-1:0]   addr_sel_c;
    logic                    write_sel_c;
    logic                    err_c;
    logic [31:0]             rd_data_c;
    logic [DATA_WIDTH-1:0]   resp_data_c;
    logic                    we_c;
    logic                    unused_pprot;

    // With zero wait states the response is formed from the live setup-phase inputs.
    assign addr_sel_c  = (state == IDLE) ? apb.paddr  : lat_addr;
    assign write_sel_c = (state == IDLE) ? apb.pwrite : lat_write;
    assign err_c       = apb_slv_decode_err(32'(addr_sel_c), write_sel_c, NUM_REGS);
    assign resp_data_c = (write_sel_c || err_c) ? '0 : DATA_WIDTH'(rd_data_c);
    assign we_c        = (state == ACCESS) && pready_q && apb.psel && apb.penable
                         && lat_write && !err_c;
    assign unused_pprot = ^apb.pprot;

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

    apb_slave_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk       (pclk),
        .clr       (preset),
        .we        (we_c),
        .wr_idx    (lat_addr[ADDR_WIDTH-1:2]),
        .wstrb     (lat_strb),
        .wdata     (lat_wdata),
        .rd_idx    (addr_sel_c[ADDR_WIDTH-1:2]),
        .rd_data_c (rd_data_c)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (apb.psel && !apb.penable) begin
                        state     <= ACCESS;
                        lat_write <= apb.pwrite;
                        lat_addr  <= apb.paddr;
                        lat_wdata <= apb.pwdata;
                        lat_strb  <= apb.pstrb;
                        cnt       <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c;
                            prdata_q  <= resp_data_c;
                        end
                    end
                end
                ACCESS: begin
                    if (!apb.psel || pready_q) begin
                        // Abort or completion: both return to IDLE with outputs cleared.
                        state     <= IDLE;
                        cnt       <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (apb.penable && (cnt != 4'd0)) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c;
                            prdata_q  <= resp_data_c;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile with WAIT_CYCLES = 0, 1 and 3 instances on one shared master.
module tb_apb_slave_regfile;
    import apb_slave_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        preset;
    logic        m_psel, m_penable, m_pwrite;
    logic [7:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    int          dut_sel;
    logic        mon_en;
    logic        prev_rdy;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata;
    exp_t        exp_q[$];
    int          n_cmp;
    int          n_err;

    apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel = m_psel && (dut_sel == 0);
    assign bus1.psel = m_psel && (dut_sel == 1);
    assign bus3.psel = m_psel && (dut_sel == 3);
    assign bus0.penable = m_penable; assign bus1.penable = m_penable; assign bus3.penable = m_penable;
    assign bus0.pwrite  = m_pwrite;  assign bus1.pwrite  = m_pwrite;  assign bus3.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;   assign bus1.paddr   = m_paddr;   assign bus3.paddr   = m_paddr;
    assign bus0.pwdata  = m_pwdata;  assign bus1.pwdata  = m_pwdata;  assign bus3.pwdata  = m_pwdata;
    assign bus0.pstrb   = m_pstrb;   assign bus1.pstrb   = m_pstrb;   assign bus3.pstrb   = m_pstrb;
    assign bus0.pprot   = m_pprot;   assign bus1.pprot   = m_pprot;   assign bus3.pprot   = m_pprot;

    assign s_pready  = (dut_sel == 0) ? bus0.pready  : (dut_sel == 3) ? bus3.pready  : bus1.pready;
    assign s_pslverr = (dut_sel == 0) ? bus0.pslverr : (dut_sel == 3) ? bus3.pslverr : bus1.pslverr;
    assign s_prdata  = (dut_sel == 0) ? bus0.prdata  : (dut_sel == 3) ? bus3.prdata  : bus1.prdata;

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (.pclk(clk), .preset(preset), .apb(bus0));
    apb_slave_regfile #(.WAIT_CYCLES(1)) u_dut1 (.pclk(clk), .preset(preset), .apb(bus1));
    apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut3 (.pclk(clk), .preset(preset), .apb(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut W=%0d, t=%0t)", tag, got, exp, dut_sel, $time);
        end
    endtask

    // Response checker: every pready pops one expected entry; outside pready the outputs must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_rdy) check("pready_one_cycle", 32'(s_pready), 32'd0);
            if (s_pready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pready", 32'(s_pready), 32'd0);
                end else begin
                    check("prdata", s_prdata, exp_q[0].rdata);
                    check("pslverr", 32'(s_pslverr), 32'(exp_q[0].err));
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_prdata", s_prdata, 32'd0);
                check("idle_pslverr", 32'(s_pslverr), 32'd0);
            end
            prev_rdy <= s_pready;
        end
    end

    // Entered and left at #1 after a rising edge, so consecutive calls run back-to-back.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        int   exp_lat;
        logic got;
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        exp_lat   = dut_sel + 1;
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_pwrite  = wr;
        m_paddr   = addr;
        m_pwdata  = wdata;
        m_pstrb   = strb;
        m_pprot   = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        m_penable = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (s_pready) got = 1'b1;
        end
        check("latency", 32'(n), 32'(exp_lat));
        if (!got && exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        mon_en = 1'b0; prev_rdy = 1'b0; dut_sel = 1;
        preset = 1'b1;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        check("rst_pready",  32'({bus0.pready, bus1.pready, bus3.pready}), 32'd0);
        check("rst_pslverr", 32'({bus0.pslverr, bus1.pslverr, bus3.pslverr}), 32'd0);
        check("rst_prdata",  bus0.prdata | bus1.prdata | bus3.prdata, 32'd0);
        mon_en = 1'b1;
        idle_cycles(1);

        // ID read, then strobed writes back-to-back with read-back
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'hA5B0_0001, 1'b0);
        xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 8'h04, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

        // Error accesses must leave register 0x08 and the ID untouched
        xfer(1'b1, 8'h08, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 8'h00, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        xfer(1'b0, 8'h06, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1'b1, 8'h09, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
        xfer(1'b1, 8'h44, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
        xfer(1'b1, 8'h08, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'hA5B0_0001, 1'b0);
        xfer(1'b0, 8'h3C, 32'h0, 4'h0, 32'h0, 1'b0);

        // penable without setup in IDLE is ignored
        m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1; m_paddr = 8'h08; m_pwdata = 32'h0; m_pstrb = 4'hF;
        idle_cycles(2);
        m_psel = 1'b0; m_penable = 1'b0;
        idle_cycles(1);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Abort: W=1 drops psel after setup, W=3 after the first access cycle
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h10; m_pwdata = 32'h5; m_pstrb = 4'hF;
        idle_cycles(1);
        m_psel = 1'b0;
        idle_cycles(4);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        dut_sel = 3;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h08; m_pwdata = 32'h5; m_pstrb = 4'hF;
        idle_cycles(1);
        m_penable = 1'b1;
        idle_cycles(1);
        m_psel = 1'b0; m_penable = 1'b0;
        idle_cycles(5);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0);

        // Latency for the other builds
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'hA5B0_0001, 1'b0);
        xfer(1'b1, 8'h14, 32'h0BAD_CAFE, 4'hC, 32'h0, 1'b0);
        xfer(1'b0, 8'h14, 32'h0, 4'h0, 32'h0BAD_0000, 1'b0);
        dut_sel = 0;
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'hA5B0_0001, 1'b0);
        xfer(1'b1, 8'h14, 32'h8765_4321, 4'h3, 32'h0, 1'b0);
        xfer(1'b0, 8'h14, 32'h0, 4'h0, 32'h0000_4321, 1'b0);
        xfer(1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1);

        // Reset in the middle of a write to 0x0C
        dut_sel = 1;
        xfer(1'b1, 8'h0C, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h0C; m_pwdata = 32'hFFFF_FFFF; m_pstrb = 4'hF;
        idle_cycles(1);
        m_penable = 1'b1; preset = 1'b1;
        idle_cycles(1);
        preset = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk);
        check("mid_rst_pready",  32'(bus1.pready), 32'd0);
        check("mid_rst_pslverr", 32'(bus1.pslverr), 32'd0);
        check("mid_rst_prdata",  bus1.prdata, 32'd0);
        idle_cycles(1);
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'hA5B0_0001, 1'b0);

        idle_cycles(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
